// File: rtl/core_wb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : core_wb_bridge_if
// Brief    : Classic Wishbone B4 signal bundle between bridge (master) and slave.
// Revision : 1.0
// ============================================================================
interface core_wb_bridge_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface
`default_nettype wire

// File: rtl/core_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : core_wb_bridge
// Brief    : RV32I MEM-stage request to single classic Wishbone cycle bridge.
//            Optional BUSY watchdog enabled by defining WB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module core_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            mem_addr_mem,
  input  logic [31:0]            mem_wdata_mem,
  input  logic                   mem_write_mem,
  input  logic                   mem_read_mem,
  input  logic [2:0]             mem_op_mem,
  output logic [31:0]            mem_rdata_mem,
  output logic                   stall_pipl,
  output logic                   bus_err,
  core_wb_bridge_if.master       wb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("core_wb_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic        misaligned;
  logic [3:0]  sel_req;
  logic [31:0] wdat_req;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;
  logic        tmo_hit;

  // funct3[1:0] picks the access size; reserved encodings fall into the word case.
  always_comb begin
    req = mem_read_mem | mem_write_mem;
    case (mem_op_mem[1:0])
      2'b00: begin
        sel_req    = 4'b0001 << mem_addr_mem[1:0];
        wdat_req   = {4{mem_wdata_mem[7:0]}};
        misaligned = 1'b0;
      end
      2'b01: begin
        sel_req    = 4'b0011 << mem_addr_mem[1:0];
        wdat_req   = {2{mem_wdata_mem[15:0]}};
        misaligned = mem_addr_mem[0];
      end
      default: begin
        sel_req    = 4'b1111;
        wdat_req   = mem_wdata_mem;
        misaligned = |mem_addr_mem[1:0];
      end
    endcase
  end

  always_comb begin
    ld_shift = wb.wb_dat_i >> {lo_q, 3'b000};
    case (op_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = wb.wb_dat_i;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_q, tmo_d;

  // Held at zero outside BUSY so it starts cleared on every entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == BUSY && !wb.wb_ack_i && !wb.wb_err_i) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    lo_d       = lo_q;
    op_d       = op_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    stall_pipl = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_pipl = 1'b1;
          if (misaligned) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = BUSY;
            adr_d   = {mem_addr_mem[31:2], 2'b00};
            dat_d   = wdat_req;
            sel_d   = sel_req;
            we_d    = mem_write_mem;
            cyc_d   = 1'b1;
            lo_d    = mem_addr_mem[1:0];
            op_d    = mem_op_mem;
          end
        end
      end
      BUSY: begin
        stall_pipl = 1'b1;
        if (wb.wb_err_i || tmo_hit) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (wb.wb_ack_i) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          if (!we_q) begin
            rdata_d = ld_ext;
          end
        end
      end
      // The request still visible here was just served; the pipeline advances now.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      lo_q    <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign wb.wb_adr_o   = adr_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_sel_o   = sel_q;
  assign wb.wb_we_o    = we_q;
  assign wb.wb_cyc_o   = cyc_q;
  assign wb.wb_stb_o   = cyc_q;
  assign mem_rdata_mem = rdata_q;
  assign bus_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_wb_bridge
// Brief    : Randomized self-checking bench for core_wb_bridge with a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_core_wb_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic [31:0] mem_rdata_mem;
  logic        stall_pipl;
  logic        bus_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_rdata = '0;

  core_wb_bridge_if wb_if ();

  core_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr_mem  (mem_addr_mem),
    .mem_wdata_mem (mem_wdata_mem),
    .mem_write_mem (mem_write_mem),
    .mem_read_mem  (mem_read_mem),
    .mem_op_mem    (mem_op_mem),
    .mem_rdata_mem (mem_rdata_mem),
    .stall_pipl    (stall_pipl),
    .bus_err       (bus_err),
    .wb            (wb_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  // Load result from the raw bus word: pick the addressed lane, then extend.
  function automatic logic [31:0] load_val(input logic [2:0] op, input int lo, input logic [31:0] d);
    longint v;
    v = longint'(d >> (8 * lo));
    case (op)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = v % 65536;
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  // resp: 0 = ack after 'waits' wait states, 1 = err (ack may also be high), 2 = never answer
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr, input int waits, input int resp,
                         input logic [31:0] sdat);
    int          size, lo, stalls, busy, exp_stalls;
    logic        mis, done, cyc_seen;
    logic [31:0] e_adr, e_sel, e_dat, e_rdata;
    logic        e_err;

    size  = access_size(op);
    lo    = int'(addr % 4);
    mis   = (addr % size) != 0;
    e_adr = addr - lo;
    e_sel = (size == 4) ? 32'd15 : (((size == 1) ? 32'd1 : 32'd3) << lo);
    e_dat = (size == 1) ? (wdata % 256) * 32'h0101_0101 :
            (size == 2) ? (wdata % 65536) * 32'h0001_0001 : wdata;
    if (mis) begin
      e_err = 1'b1; e_rdata = '0; exp_stalls = 1;
    end else if (resp == 1) begin
      e_err = 1'b1; e_rdata = '0; exp_stalls = waits + 2;
    end else if (resp == 2) begin
      e_err = 1'b1; e_rdata = '0; exp_stalls = TMO + 1;
    end else begin
      e_err = 1'b0; e_rdata = wr ? model_rdata : load_val(op, lo, sdat); exp_stalls = waits + 2;
    end

    @(negedge clk);
    mem_addr_mem = addr; mem_wdata_mem = wdata; mem_op_mem = op;
    mem_read_mem = rd; mem_write_mem = wr;
    wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0; wb_if.wb_dat_i = $urandom;
    stalls = 0; busy = 0; done = 1'b0; cyc_seen = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!stall_pipl) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (wb_if.wb_cyc_o) begin
          cyc_seen = 1'b1;
          busy++;
          check_eq("wb_adr_o", wb_if.wb_adr_o, e_adr);
          check_eq("wb_sel_o", 32'(wb_if.wb_sel_o), e_sel);
          check_eq("wb_dat_o", wb_if.wb_dat_o, e_dat);
          check_eq("wb_we_o", 32'(wb_if.wb_we_o), 32'(wr));
          check_eq("wb_stb_o", 32'(wb_if.wb_stb_o), 32'd1);
          wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0; wb_if.wb_dat_i = $urandom;
          if (busy > waits && resp == 0) begin
            wb_if.wb_ack_i = 1'b1; wb_if.wb_dat_i = sdat;
          end else if (busy > waits && resp == 1) begin
            wb_if.wb_err_i = 1'b1; wb_if.wb_ack_i = 1'($urandom_range(0, 1));
          end
        end
        @(negedge clk);
      end
    end
    check_eq("done_in_budget", 32'(done), 32'd1);
    check_eq("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check_eq("cyc_issued", 32'(cyc_seen), 32'(!mis));
    check_eq("cyc_dropped", 32'(wb_if.wb_cyc_o), 32'd0);
    check_eq("bus_err_done", 32'(bus_err), 32'(e_err));
    check_eq("rdata_done", mem_rdata_mem, e_rdata);
    model_rdata = e_rdata;
    mem_read_mem = 1'b0; mem_write_mem = 1'b0;
    wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0;
    @(negedge clk);
    #1;
    check_eq("bus_err_cleared", 32'(bus_err), 32'd0);
    check_eq("idle_stall", 32'(stall_pipl), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    int          kind;

    reset_n = 1'b0;
    mem_addr_mem = '0; mem_wdata_mem = '0; mem_op_mem = '0;
    mem_read_mem = 1'b0; mem_write_mem = 1'b0;
    wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0; wb_if.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_adr", wb_if.wb_adr_o, 32'h0);
    check_eq("rst_dat", wb_if.wb_dat_o, 32'h0);
    check_eq("rst_sel", 32'(wb_if.wb_sel_o), 32'h0);
    check_eq("rst_we", 32'(wb_if.wb_we_o), 32'h0);
    check_eq("rst_cyc", 32'(wb_if.wb_cyc_o), 32'h0);
    check_eq("rst_stb", 32'(wb_if.wb_stb_o), 32'h0);
    check_eq("rst_rdata", mem_rdata_mem, 32'h0);
    check_eq("rst_bus_err", 32'(bus_err), 32'h0);
    check_eq("rst_stall", 32'(stall_pipl), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_txn(3'b010, 32'h100, 32'h0, 1'b1, 1'b0, 0, 0, 32'h8765_4321);
    run_txn(3'b000, 32'h103, 32'h0, 1'b1, 1'b0, 0, 0, 32'h8012_3456);
    run_txn(3'b100, 32'h103, 32'h0, 1'b1, 1'b0, 1, 0, 32'h80FE_DCBA);
    run_txn(3'b001, 32'h102, 32'h0, 1'b1, 1'b0, 0, 0, 32'h8001_5555);
    run_txn(3'b101, 32'h102, 32'h0, 1'b1, 1'b0, 0, 0, 32'h8001_5555);
    run_txn(3'b001, 32'h206, 32'h1234_ABCD, 1'b0, 1'b1, 2, 0, 32'h0);
    run_txn(3'b000, 32'h301, 32'hFFFF_FF5A, 1'b1, 1'b1, 0, 0, 32'h0);
    run_txn(3'b010, 32'h102, 32'h0, 1'b1, 1'b0, 0, 0, 32'h0);
    run_txn(3'b010, 32'h100, 32'h0, 1'b1, 1'b0, 0, 1, 32'h1111_1111);
    run_txn(3'b110, 32'h40C, 32'h0, 1'b1, 1'b0, 0, 0, 32'hCAFE_F00D);

    for (int i = 0; i < 150; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      kind = $urandom_range(0, 3);
      run_txn(op, addr, $urandom, kind != 1, kind == 1 || kind == 2,
              $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom);
    end

`ifdef WB_TIMEOUT_EN
    run_txn(3'b010, 32'h300, 32'h0, 1'b1, 1'b0, 0, 2, 32'h0);
`endif

    // Abandon a never-answered cycle with an asynchronous reset.
    @(negedge clk);
    mem_addr_mem = 32'h400; mem_op_mem = 3'b010; mem_read_mem = 1'b1; mem_write_mem = 1'b0;
    wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0;
`ifdef WB_TIMEOUT_EN
    repeat (5) @(negedge clk);
`else
    repeat (40) @(negedge clk);
`endif
    #1;
    check_eq("hang_stall", 32'(stall_pipl), 32'd1);
    check_eq("hang_cyc", 32'(wb_if.wb_cyc_o), 32'd1);
    reset_n = 1'b0;
    mem_read_mem = 1'b0;
    #1;
    check_eq("arst_cyc", 32'(wb_if.wb_cyc_o), 32'd0);
    check_eq("arst_stb", 32'(wb_if.wb_stb_o), 32'd0);
    check_eq("arst_stall", 32'(stall_pipl), 32'd0);
    check_eq("arst_adr", wb_if.wb_adr_o, 32'h0);
    check_eq("arst_rdata", mem_rdata_mem, 32'h0);
    model_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(3'b010, 32'h500, 32'h0, 1'b1, 1'b0, 0, 0, 32'h0BAD_C0DE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
